// File: rtl/pulse_channel.sv
// rtl/pulse_channel.sv - square-wave sound channel with length counter, volume envelope and optional sweep
module pulse_channel #(
   parameter int SAMPLE_W  = 20,
   parameter int HAS_SWEEP = 1,
   parameter int AMP_SHIFT = 2
) (
   input  logic                I_BITCLK,
   input  logic                I_RESET,
   input  logic                I_STROBE,
   input  logic                I_FTICK,
   input  logic                I_FS_TICK,
   input  logic                I_TRIGGER,
   input  logic [10:0]         I_FREQUENCY,
   input  logic [1:0]          I_DUTY_CYCLE,
   input  logic [3:0]          I_VOLUME,
   input  logic                I_ENV_DIR,
   input  logic [2:0]          I_ENV_PERIOD,
   input  logic [5:0]          I_LENGTH,
   input  logic                I_LENGTH_EN,
   input  logic [2:0]          I_SWEEP_PERIOD,
   input  logic                I_SWEEP_DIR,
   input  logic [2:0]          I_SWEEP_SHIFT,
   input  logic                I_WAVEFORM_EN,
   output logic [SAMPLE_W-1:0] O_SAMPLE,
   output logic                O_ACTIVE,
   output logic [10:0]         O_FREQ_CUR
);

   localparam longint unsigned FULL_SCALE = (64'd1 << (SAMPLE_W - 1)) - 64'd1;

   logic [SAMPLE_W-1:0] amp_tbl [16];

   for (genvar g = 0; g < 16; g++) begin : g_amp
      localparam longint unsigned AMP_VAL = ((FULL_SCALE * 64'(g)) / 64'd15) >> AMP_SHIFT;
      assign amp_tbl[g] = AMP_VAL[SAMPLE_W-1:0];
   end

   logic [11:0] timer;
   logic [2:0]  pos;
   logic [2:0]  fs_step;
   logic [6:0]  len_cnt;
   logic [3:0]  vol;
   logic [2:0]  env_cnt;
   logic [10:0] shadow;
   logic [3:0]  sweep_cnt;
   logic        sweep_on;

   function automatic logic [11:0] sweep_calc(input logic [10:0] base, input logic [2:0] n,
                                              input logic sub);
      logic [11:0] delta;
      delta = {1'b0, base} >> n;
      return sub ? ({1'b0, base} - delta) : ({1'b0, base} + delta);
   endfunction

   logic [11:0]         sw_next;
   logic [11:0]         sw_trig;
   logic                sw_ovf;
   logic                trig_ovf;
   logic                len_clk;
   logic                sweep_clk;
   logic                env_clk;
   logic [2:0]          duty_thr;
   logic                high;
   logic [SAMPLE_W-1:0] amp;
   logic [3:0]          sweep_reload;

   assign sw_next      = sweep_calc(shadow, I_SWEEP_SHIFT, I_SWEEP_DIR);
   assign sw_ovf       = !I_SWEEP_DIR && sw_next[11];
   // The trigger-time overflow check runs on the frequency being loaded, not the old shadow
   assign sw_trig      = sweep_calc(I_FREQUENCY, I_SWEEP_SHIFT, I_SWEEP_DIR);
   assign trig_ovf     = (HAS_SWEEP != 0) && (I_SWEEP_SHIFT != 3'd0) && !I_SWEEP_DIR && sw_trig[11];
   assign len_clk      = I_FS_TICK && !fs_step[0];
   assign sweep_clk    = I_FS_TICK && (fs_step[1:0] == 2'b10);
   assign env_clk      = I_FS_TICK && (fs_step == 3'd7);
   assign sweep_reload = (I_SWEEP_PERIOD == 3'd0) ? 4'd8 : {1'b0, I_SWEEP_PERIOD};

   always_comb begin
      duty_thr = 3'd1;
      case (I_DUTY_CYCLE)
         2'b00:   duty_thr = 3'd1;
         2'b01:   duty_thr = 3'd2;
         2'b10:   duty_thr = 3'd4;
         default: duty_thr = 3'd6;
      endcase
   end

   assign high = pos < duty_thr;
   assign amp  = amp_tbl[vol];

   always_ff @(posedge I_BITCLK) begin
      if (I_RESET) begin
         O_SAMPLE   <= '0;
         O_ACTIVE   <= 1'b0;
         O_FREQ_CUR <= '0;
         timer      <= '0;
         pos        <= '0;
         fs_step    <= '0;
         len_cnt    <= '0;
         vol        <= '0;
         env_cnt    <= '0;
         shadow     <= '0;
         sweep_cnt  <= '0;
         sweep_on   <= 1'b0;
      end else begin
         if (I_STROBE)
            O_SAMPLE <= (O_ACTIVE && I_WAVEFORM_EN) ? (high ? amp : -amp) : '0;
         if (HAS_SWEEP == 0)
            O_FREQ_CUR <= I_FREQUENCY;

         if (I_TRIGGER) begin
            pos     <= '0;
            timer   <= 12'd2048 - {1'b0, I_FREQUENCY};
            len_cnt <= 7'd64 - {1'b0, I_LENGTH};
            vol     <= I_VOLUME;
            env_cnt <= I_ENV_PERIOD;
            if (HAS_SWEEP != 0) begin
               shadow     <= I_FREQUENCY;
               O_FREQ_CUR <= I_FREQUENCY;
               sweep_cnt  <= sweep_reload;
               sweep_on   <= (I_SWEEP_PERIOD != 3'd0) || (I_SWEEP_SHIFT != 3'd0);
            end
            O_ACTIVE <= !((I_VOLUME == 4'd0) && !I_ENV_DIR) && !trig_ovf;
         end else begin
            if (I_FTICK) begin
               if (timer <= 12'd1) begin
                  timer <= 12'd2048 - {1'b0, O_FREQ_CUR};
                  pos   <= pos + 3'd1;
               end else begin
                  timer <= timer - 12'd1;
               end
            end
            if (I_FS_TICK)
               fs_step <= fs_step + 3'd1;

            // Length, envelope and sweep only advance while the channel is playing
            if (O_ACTIVE) begin
               if (len_clk && I_LENGTH_EN && (len_cnt != 7'd0)) begin
                  len_cnt <= len_cnt - 7'd1;
                  if (len_cnt == 7'd1)
                     O_ACTIVE <= 1'b0;
               end
               if (env_clk && (I_ENV_PERIOD != 3'd0)) begin
                  if (env_cnt <= 3'd1) begin
                     env_cnt <= I_ENV_PERIOD;
                     if (I_ENV_DIR && (vol != 4'd15))
                        vol <= vol + 4'd1;
                     else if (!I_ENV_DIR && (vol != 4'd0))
                        vol <= vol - 4'd1;
                  end else begin
                     env_cnt <= env_cnt - 3'd1;
                  end
               end
               if ((HAS_SWEEP != 0) && sweep_clk) begin
                  if (sweep_cnt <= 4'd1) begin
                     sweep_cnt <= sweep_reload;
                     if (sweep_on && (I_SWEEP_PERIOD != 3'd0)) begin
                        if (sw_ovf) begin
                           O_ACTIVE <= 1'b0;
                        end else if (I_SWEEP_SHIFT != 3'd0) begin
                           shadow     <= sw_next[10:0];
                           O_FREQ_CUR <= sw_next[10:0];
                        end
                     end
                  end else begin
                     sweep_cnt <= sweep_cnt - 4'd1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_pulse_channel.sv
// tb/tb_pulse_channel.sv - directed self-checking bench for pulse_channel
module tb_pulse_channel;

   localparam logic [31:0] AMP15 = 32'h1FFFF;
   localparam logic [31:0] NEG15 = 32'hE0001;
   localparam logic [31:0] AMP2  = 32'h04444;
   localparam logic [31:0] AMP1  = 32'h02222;
   localparam logic [31:0] NEG1  = 32'hFDDDE;

   logic        I_BITCLK = 1'b0;
   logic        I_RESET;
   logic        I_STROBE;
   logic        I_FTICK;
   logic        I_FS_TICK;
   logic        I_TRIGGER;
   logic [10:0] I_FREQUENCY;
   logic [1:0]  I_DUTY_CYCLE;
   logic [3:0]  I_VOLUME;
   logic        I_ENV_DIR;
   logic [2:0]  I_ENV_PERIOD;
   logic [5:0]  I_LENGTH;
   logic        I_LENGTH_EN;
   logic [2:0]  I_SWEEP_PERIOD;
   logic        I_SWEEP_DIR;
   logic [2:0]  I_SWEEP_SHIFT;
   logic        I_WAVEFORM_EN;
   logic [19:0] O_SAMPLE;
   logic        O_ACTIVE;
   logic [10:0] O_FREQ_CUR;

   int n_checks = 0;
   int n_errors = 0;

   pulse_channel #(
      .SAMPLE_W  (20),
      .HAS_SWEEP (1),
      .AMP_SHIFT (2)
   ) dut (
      .I_BITCLK       (I_BITCLK),
      .I_RESET        (I_RESET),
      .I_STROBE       (I_STROBE),
      .I_FTICK        (I_FTICK),
      .I_FS_TICK      (I_FS_TICK),
      .I_TRIGGER      (I_TRIGGER),
      .I_FREQUENCY    (I_FREQUENCY),
      .I_DUTY_CYCLE   (I_DUTY_CYCLE),
      .I_VOLUME       (I_VOLUME),
      .I_ENV_DIR      (I_ENV_DIR),
      .I_ENV_PERIOD   (I_ENV_PERIOD),
      .I_LENGTH       (I_LENGTH),
      .I_LENGTH_EN    (I_LENGTH_EN),
      .I_SWEEP_PERIOD (I_SWEEP_PERIOD),
      .I_SWEEP_DIR    (I_SWEEP_DIR),
      .I_SWEEP_SHIFT  (I_SWEEP_SHIFT),
      .I_WAVEFORM_EN  (I_WAVEFORM_EN),
      .O_SAMPLE       (O_SAMPLE),
      .O_ACTIVE       (O_ACTIVE),
      .O_FREQ_CUR     (O_FREQ_CUR)
   );

   always #5 I_BITCLK = ~I_BITCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge I_BITCLK);
      #1;
   endtask

   task automatic do_reset();
      I_RESET        = 1'b1;
      I_STROBE       = 1'b0;
      I_FTICK        = 1'b0;
      I_FS_TICK      = 1'b0;
      I_TRIGGER      = 1'b0;
      I_FREQUENCY    = '0;
      I_DUTY_CYCLE   = '0;
      I_VOLUME       = '0;
      I_ENV_DIR      = 1'b0;
      I_ENV_PERIOD   = '0;
      I_LENGTH       = '0;
      I_LENGTH_EN    = 1'b0;
      I_SWEEP_PERIOD = '0;
      I_SWEEP_DIR    = 1'b0;
      I_SWEEP_SHIFT  = '0;
      I_WAVEFORM_EN  = 1'b0;
      tick();
      tick();
      I_RESET = 1'b0;
   endtask

   task automatic trigger();
      I_TRIGGER = 1'b1;
      tick();
      I_TRIGGER = 1'b0;
   endtask

   task automatic pulse_fs(input int count);
      for (int i = 0; i < count; i++) begin
         I_FS_TICK = 1'b1;
         tick();
         I_FS_TICK = 1'b0;
         tick();
      end
   endtask

   initial begin
      // reset state
      do_reset();
      check("reset_sample", 32'(O_SAMPLE), 32'd0);
      check("reset_active", 32'(O_ACTIVE), 32'd0);
      check("reset_freq", 32'(O_FREQ_CUR), 32'd0);

      // 1: f=2047, 50% duty, full volume
      I_FREQUENCY = 11'd2047; I_DUTY_CYCLE = 2'b10; I_VOLUME = 4'd15; I_WAVEFORM_EN = 1'b1;
      I_FTICK = 1'b1; I_STROBE = 1'b1;
      check("t1_active_pre", 32'(O_ACTIVE), 32'd0);
      trigger();
      check("t1_active_post", 32'(O_ACTIVE), 32'd1);
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("t1_sample%0d", k), 32'(O_SAMPLE), (k <= 4) ? AMP15 : NEG15);
      end

      // 2: f=2040 (reload 8), 12.5% duty, vol 1, then live duty change
      do_reset();
      I_FREQUENCY = 11'd2040; I_DUTY_CYCLE = 2'b00; I_VOLUME = 4'd1; I_WAVEFORM_EN = 1'b1;
      I_FTICK = 1'b1; I_STROBE = 1'b1;
      trigger();
      for (int k = 0; k < 72; k++) begin
         tick();
         check($sformatf("t2_sample%0d", k), 32'(O_SAMPLE), ((k % 64) < 8) ? AMP1 : NEG1);
      end
      tick();
      check("t2_pos1_a", 32'(O_SAMPLE), NEG1);
      tick();
      check("t2_pos1_b", 32'(O_SAMPLE), NEG1);
      I_DUTY_CYCLE = 2'b11;
      tick();
      check("t2_duty_live", 32'(O_SAMPLE), AMP1);

      // 3: length counter 2 -> 0 over steps 0,1,2
      do_reset();
      I_FREQUENCY = 11'd2047; I_DUTY_CYCLE = 2'b10; I_VOLUME = 4'd15; I_WAVEFORM_EN = 1'b1;
      I_STROBE = 1'b1; I_LENGTH = 6'd62; I_LENGTH_EN = 1'b1;
      trigger();
      pulse_fs(1);
      check("t3_active_s0", 32'(O_ACTIVE), 32'd1);
      pulse_fs(1);
      check("t3_active_s1", 32'(O_ACTIVE), 32'd1);
      pulse_fs(1);
      check("t3_active_s2", 32'(O_ACTIVE), 32'd0);
      check("t3_sample_off", 32'(O_SAMPLE), 32'd0);

      do_reset();
      I_FREQUENCY = 11'd2047; I_DUTY_CYCLE = 2'b10; I_VOLUME = 4'd15; I_WAVEFORM_EN = 1'b1;
      I_STROBE = 1'b1; I_LENGTH = 6'd62; I_LENGTH_EN = 1'b0;
      trigger();
      pulse_fs(3);
      check("t3_noen_active", 32'(O_ACTIVE), 32'd1);
      check("t3_noen_sample", 32'(O_SAMPLE), AMP15);

      // 4: envelope decay 2 -> 1 -> 0, saturating
      do_reset();
      I_FREQUENCY = 11'd2047; I_DUTY_CYCLE = 2'b10; I_VOLUME = 4'd2; I_WAVEFORM_EN = 1'b1;
      I_STROBE = 1'b1; I_ENV_PERIOD = 3'd1;
      trigger();
      tick();
      check("t4_vol2", 32'(O_SAMPLE), AMP2);
      pulse_fs(8);
      check("t4_vol1", 32'(O_SAMPLE), AMP1);
      pulse_fs(8);
      check("t4_vol0", 32'(O_SAMPLE), 32'd0);
      pulse_fs(8);
      check("t4_vol0_hold", 32'(O_SAMPLE), 32'd0);

      do_reset();
      I_FREQUENCY = 11'd2047; I_VOLUME = 4'd0; I_ENV_DIR = 1'b0; I_WAVEFORM_EN = 1'b1;
      trigger();
      tick();
      check("t4_dac_off", 32'(O_ACTIVE), 32'd0);

      // 5: trigger-time sweep overflow, with shift 0 as control
      do_reset();
      I_FREQUENCY = 11'h7F0; I_VOLUME = 4'd15; I_SWEEP_SHIFT = 3'd0; I_WAVEFORM_EN = 1'b1;
      trigger();
      check("t5_no_shift", 32'(O_ACTIVE), 32'd1);
      do_reset();
      I_FREQUENCY = 11'h7F0; I_VOLUME = 4'd15; I_SWEEP_SHIFT = 3'd1; I_WAVEFORM_EN = 1'b1;
      trigger();
      check("t5_overflow", 32'(O_ACTIVE), 32'd0);

      // 6: sweep 0x400 -> 0x600 at step 2, overflow at step 6
      do_reset();
      I_FREQUENCY = 11'h400; I_VOLUME = 4'd15; I_SWEEP_SHIFT = 3'd1; I_SWEEP_PERIOD = 3'd1;
      I_WAVEFORM_EN = 1'b1;
      trigger();
      check("t6_freq_trig", 32'(O_FREQ_CUR), 32'h400);
      pulse_fs(2);
      check("t6_freq_s1", 32'(O_FREQ_CUR), 32'h400);
      pulse_fs(1);
      check("t6_freq_s2", 32'(O_FREQ_CUR), 32'h600);
      check("t6_active_s2", 32'(O_ACTIVE), 32'd1);
      pulse_fs(3);
      check("t6_active_s5", 32'(O_ACTIVE), 32'd1);
      pulse_fs(1);
      check("t6_active_s6", 32'(O_ACTIVE), 32'd0);
      check("t6_freq_s6", 32'(O_FREQ_CUR), 32'h600);

      // 7: trigger wins over coincident ticks; reset mid-tone
      do_reset();
      I_FREQUENCY = 11'd2047; I_DUTY_CYCLE = 2'b10; I_VOLUME = 4'd15; I_WAVEFORM_EN = 1'b1;
      I_FTICK = 1'b1; I_STROBE = 1'b1;
      trigger();
      tick(); tick(); tick();
      pulse_fs(3);
      I_TRIGGER = 1'b1; I_FS_TICK = 1'b1;
      tick();
      I_TRIGGER = 1'b0; I_FS_TICK = 1'b0;
      check("t7_pos", 32'(dut.pos), 32'd0);
      check("t7_fs_step", 32'(dut.fs_step), 32'd3);
      tick();
      check("t7_sample", 32'(O_SAMPLE), AMP15);
      I_RESET = 1'b1;
      tick();
      check("t7_rst_sample", 32'(O_SAMPLE), 32'd0);
      check("t7_rst_active", 32'(O_ACTIVE), 32'd0);
      check("t7_rst_freq", 32'(O_FREQ_CUR), 32'd0);
      I_RESET = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
